// File: rtl/float_accum_seq_bf16_if.sv
// rtl/float_accum_seq_bf16_if.sv - element stream, adder operand/result and reduced-output signal bundle
//
// Purpose: groups every handshake and data signal of float_accum_seq_bf16
// except clock and reset.
//   slave  : the sequencer side (element sink, adder operand source, result source)
//   master : the surrounding side (element source, adder, result sink)
// Signals:
//   in_data/in_valid/in_last/in_ready : bf16 element stream
//   add_a/add_b/add_req               : operand pair issued to the external adder
//   add_y/add_valid                   : adder result
//   out_data/out_count/out_valid/out_ready : reduced sum and element count
interface float_accum_seq_bf16_if #(
    parameter int CNT_W = 4
);
    logic [15:0]      in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic             add_req;
    logic [15:0]      add_y;
    logic             add_valid;
    logic [15:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_data, in_valid, in_last, add_y, add_valid, out_ready,
        output in_ready, add_a, add_b, add_req, out_data, out_count, out_valid
    );

    modport master (
        output in_data, in_valid, in_last, add_y, add_valid, out_ready,
        input  in_ready, add_a, add_b, add_req, out_data, out_count, out_valid
    );
endinterface

// File: rtl/float_accum_seq_bf16.sv
// rtl/float_accum_seq_bf16.sv - streaming bf16 reduction sequencer driving an external bf16 adder
//
// Purpose: accepts VEC_LEN bf16 elements (or fewer, closed by in_last), feeds
// each element plus the running sum to an external adder, captures the adder
// result as the new sum and presents the reduced value with its element count.
// No arithmetic happens here; the first element is loaded bit-exact.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : float_accum_seq_bf16_if.slave (element stream, adder port, result port)
// Optional build macro:
//   FLOAT_ACC_SKIP_ZERO_EN : +/-0 elements after the first bypass the adder (1 cycle each)
module float_accum_seq_bf16 #(
    parameter int VEC_LEN = 8,
    parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input logic                  clock,
    input logic                  reset,
    float_accum_seq_bf16_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        ADD    = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(VEC_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_n;
    logic [15:0]      acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_q, last_n;
    logic [15:0]      add_a_r, add_a_n;
    logic [15:0]      add_b_r, add_b_n;
    logic [15:0]      out_data_r, out_data_n;
    logic [CNT_W-1:0] out_count_r, out_count_n;
    logic             in_ready_c;
    logic             add_req_c;
    logic             out_valid_c;

    assign cnt_inc = cnt + CNT_ONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            last_q      <= 1'b0;
            add_a_r     <= '0;
            add_b_r     <= '0;
            out_data_r  <= '0;
            out_count_r <= '0;
        end else begin
            state       <= state_n;
            acc         <= acc_n;
            cnt         <= cnt_n;
            last_q      <= last_n;
            add_a_r     <= add_a_n;
            add_b_r     <= add_b_n;
            out_data_r  <= out_data_n;
            out_count_r <= out_count_n;
        end
    end

    // out_data/out_count are their own registers, loaded on entry to DONE,
    // so they keep the last result after acc and cnt are cleared.
    always_comb begin
        state_n     = state;
        acc_n       = acc;
        cnt_n       = cnt;
        last_n      = last_q;
        add_a_n     = add_a_r;
        add_b_n     = add_b_r;
        out_data_n  = out_data_r;
        out_count_n = out_count_r;
        in_ready_c  = 1'b0;
        add_req_c   = 1'b0;
        out_valid_c = 1'b0;

        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    acc_n = bus.in_data;
                    cnt_n = CNT_ONE;
                    if (bus.in_last || (VEC_LEN == 1)) begin
                        state_n     = DONE;
                        out_data_n  = bus.in_data;
                        out_count_n = CNT_ONE;
                    end else begin
                        state_n = ACCEPT;
                    end
                end
            end

            ACCEPT: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    cnt_n  = cnt_inc;
                    last_n = bus.in_last || (cnt_inc == CNT_MAX);
`ifdef FLOAT_ACC_SKIP_ZERO_EN
                    if (bus.in_data[14:0] == 15'd0) begin
                        // Adding +/-0 cannot change a non-zero sum; consume it here.
                        if (last_n) begin
                            state_n     = DONE;
                            out_data_n  = acc;
                            out_count_n = cnt_inc;
                        end
                    end else begin
                        add_a_n = acc;
                        add_b_n = bus.in_data;
                        state_n = ADD;
                    end
`else
                    add_a_n = acc;
                    add_b_n = bus.in_data;
                    state_n = ADD;
`endif
                end
            end

            ADD: begin
                add_req_c = 1'b1;
                if (bus.add_valid) begin
                    acc_n = bus.add_y;
                    if (last_q) begin
                        state_n     = DONE;
                        out_data_n  = bus.add_y;
                        out_count_n = cnt;
                    end else begin
                        state_n = ACCEPT;
                    end
                end
            end

            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    acc_n   = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is held, whatever the state.
    assign bus.in_ready  = in_ready_c  & ~reset;
    assign bus.add_req   = add_req_c   & ~reset;
    assign bus.out_valid = out_valid_c & ~reset;
    assign bus.add_a     = add_a_r;
    assign bus.add_b     = add_b_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_count = out_count_r;
endmodule

// File: tb/tb_float_accum_seq_bf16.sv
// tb/tb_float_accum_seq_bf16.sv - directed self-checking bench for float_accum_seq_bf16
module tb_float_accum_seq_bf16;
    localparam int VEC_LEN = 4;
    localparam int CNT_W   = 3;
    localparam int LIMIT   = 40;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic av    = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   add_done = 0;
    int   req_cycles = 0;
    int   acc_cyc = 0;
    int   first_cyc = 0;
    int   snap = 0;
    int   n;
    logic [15:0] hold_a, hold_b;

    always #5 clock = ~clock;

    float_accum_seq_bf16_if #(.CNT_W(CNT_W)) bus ();

    float_accum_seq_bf16 #(.VEC_LEN(VEC_LEN), .CNT_W(CNT_W)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Hand-computed bf16 sums for the operand pairs used below.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] k;
        k = {a, b};
        case (k)
            32'h3F80_3F80: return 16'h4000;
            32'h4000_3F80: return 16'h4040;
            32'h4040_3F80: return 16'h4080;
            32'h3F80_0000: return 16'h3F80;
            default:       return 16'h7FC1;
        endcase
    endfunction

    assign bus.add_y     = ref_add(bus.add_a, bus.add_b);
    assign bus.add_valid = av;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bus.add_req) req_cycles <= req_cycles + 1;
        if (bus.add_req && bus.add_valid) add_done <= add_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        check("send_ready", {31'd0, bus.in_ready}, 32'd1);
        acc_cyc = cyc + 1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_out();
        n = 0;
        while (!bus.out_valid && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        check("out_valid_seen", {31'd0, bus.out_valid}, 32'd1);
    endtask

    initial begin
        bus.in_data   = 16'h0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        check("rst_add_req",   {31'd0, bus.add_req}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_add_a",     {16'd0, bus.add_a}, 32'd0);
        check("rst_add_b",     {16'd0, bus.add_b}, 32'd0);
        check("rst_out_data",  {16'd0, bus.out_data}, 32'd0);
        check("rst_out_count", {29'd0, bus.out_count}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Full vector of four 1.0 closes on count, no in_last
        bus.out_ready = 1'b1;
        send(16'h3F80, 1'b0);
        first_cyc = acc_cyc;
        send(16'h3F80, 1'b0);
        send(16'h3F80, 1'b0);
        send(16'h3F80, 1'b0);
        wait_out();
        check("full_latency", cyc - first_cyc, 32'd6);
        check("full_data",    {16'd0, bus.out_data}, 32'h4080);
        check("full_count",   {29'd0, bus.out_count}, 32'd4);
        @(negedge clock);
        check("full_back_idle", {31'd0, bus.in_ready}, 32'd1);
        check("full_out_drop",  {31'd0, bus.out_valid}, 32'd0);

        // Early in_last, then hold out_ready low with in_valid pressing
        bus.out_ready = 1'b0;
        send(16'h4000, 1'b0);
        send(16'h3F80, 1'b1);
        wait_out();
        check("early_data",  {16'd0, bus.out_data}, 32'h4040);
        check("early_count", {29'd0, bus.out_count}, 32'd2);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_out_data",  {16'd0, bus.out_data}, 32'h4040);
            check("hold_out_count", {29'd0, bus.out_count}, 32'd2);
            check("hold_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("release_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("release_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        check("release_data_held", {16'd0, bus.out_data}, 32'h4040);
        bus.out_ready = 1'b0;

        // Single -0.0 element is passed through bit-exact with no add
        snap = req_cycles;
        send(16'h8000, 1'b1);
        first_cyc = acc_cyc;
        wait_out();
        check("single_latency", cyc - first_cyc, 32'd0);
        check("single_data",    {16'd0, bus.out_data}, 32'h8000);
        check("single_count",   {29'd0, bus.out_count}, 32'd1);
        check("single_no_add",  req_cycles - snap, 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;

        // Adder stall: operands stable, result taken when add_valid rises
        av = 1'b0;
        send(16'h3F80, 1'b0);
        send(16'h3F80, 1'b1);
        hold_a = bus.add_a;
        hold_b = bus.add_b;
        check("stall_add_a", {16'd0, hold_a}, 32'h3F80);
        check("stall_add_b", {16'd0, hold_b}, 32'h3F80);
        for (int i = 0; i < 3; i++) begin
            check("stall_add_req",  {31'd0, bus.add_req}, 32'd1);
            check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("stall_a_stable", {16'd0, bus.add_a}, {16'd0, hold_a});
            check("stall_b_stable", {16'd0, bus.add_b}, {16'd0, hold_b});
            @(negedge clock);
        end
        check("stall_no_out", {31'd0, bus.out_valid}, 32'd0);
        av = 1'b1;
        @(negedge clock);
        check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("stall_out_data",  {16'd0, bus.out_data}, 32'h4000);
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;

        // Reset while in ADD discards everything
        av = 1'b0;
        send(16'h4000, 1'b0);
        send(16'h3F80, 1'b0);
        check("pre_rst_add_req", {31'd0, bus.add_req}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_add_req",   {31'd0, bus.add_req}, 32'd0);
        check("mid_rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_add_a",     {16'd0, bus.add_a}, 32'd0);
        check("mid_rst_add_b",     {16'd0, bus.add_b}, 32'd0);
        check("mid_rst_out_data",  {16'd0, bus.out_data}, 32'd0);
        check("mid_rst_out_count", {29'd0, bus.out_count}, 32'd0);
        reset = 1'b0;
        av    = 1'b1;
        @(negedge clock);
        check("after_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        send(16'h3F80, 1'b0);
        send(16'h3F80, 1'b1);
        wait_out();
        check("after_rst_data",  {16'd0, bus.out_data}, 32'h4000);
        check("after_rst_count", {29'd0, bus.out_count}, 32'd2);
        bus.out_ready = 1'b1;
        @(negedge clock);

        // Zero element in the middle of a vector
        snap = add_done;
        send(16'h3F80, 1'b0);
        first_cyc = acc_cyc;
        send(16'h0000, 1'b0);
        send(16'h3F80, 1'b1);
        wait_out();
        check("zero_data",  {16'd0, bus.out_data}, 32'h4000);
        check("zero_count", {29'd0, bus.out_count}, 32'd3);
`ifdef FLOAT_ACC_SKIP_ZERO_EN
        check("zero_latency", cyc - first_cyc, 32'd3);
        check("zero_adds",    add_done - snap, 32'd1);
`else
        check("zero_latency", cyc - first_cyc, 32'd4);
        check("zero_adds",    add_done - snap, 32'd2);
`endif
        @(negedge clock);
        check("zero_back_idle", {31'd0, bus.in_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
